// File: rtl/spi_cmd_pkg.sv
// Shared types and limits for the host-side SPI command master.
package spi_cmd_pkg;

  localparam int SPI_MIN_CLK_DIV  = 2;
  localparam int LATCH_MIN_CYCLES = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    LATCH = 3'd4,
    GAP   = 3'd5
  } spi_state_e;

endpackage

// File: rtl/spi_half_period_tick.sv
// Half-period timebase: pulses tick on the last clock of every CLK_DIV-clock window.
module spi_half_period_tick
  import spi_cmd_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 32'sd1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1'b1);

  if (CLK_DIV < SPI_MIN_CLK_DIV) begin : g_div_check
    $error("spi_half_period_tick: CLK_DIV must be at least %0d", SPI_MIN_CLK_DIV);
  end

  logic [DIV_W-1:0] div_cnt_r;

  // Divider counter; clear holds it at zero so a fresh window starts on release.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      div_cnt_r <= {DIV_W{1'b0}};
    end else if (clear) begin
      div_cnt_r <= {DIV_W{1'b0}};
    end else if (div_cnt_r == DIV_LAST) begin
      div_cnt_r <= {DIV_W{1'b0}};
    end else begin
      div_cnt_r <= div_cnt_r + DIV_ONE;
    end
  end

  assign tick = !clear && (div_cnt_r == DIV_LAST);

endmodule

// File: rtl/spi_cmd_master.sv
// SPI mode-0 command master: one DATA_WIDTH-bit frame per accepted word,
// full-duplex capture on miso, optional latch_data strobe after the frame.
module spi_cmd_master
  import spi_cmd_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int CLK_DIV      = 4,
  parameter int LATCH_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic                  cmd_latch,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  busy,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  ss_n,
  input  logic                  miso,
  output logic                  latch_data
);

  localparam int BIT_CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [BIT_CNT_W-1:0] BIT_LAST   = BIT_CNT_W'(DATA_WIDTH - 32'sd1);
  localparam logic [BIT_CNT_W-1:0] LATCH_LAST = BIT_CNT_W'(LATCH_CYCLES - 32'sd1);
  localparam logic [BIT_CNT_W-1:0] CNT_ONE    = BIT_CNT_W'(1'b1);
  localparam logic [BIT_CNT_W-1:0] CNT_ZERO   = {BIT_CNT_W{1'b0}};

  if (CLK_DIV < SPI_MIN_CLK_DIV) begin : g_div_check
    $error("spi_cmd_master: CLK_DIV must be at least %0d", SPI_MIN_CLK_DIV);
  end
  if (LATCH_CYCLES < LATCH_MIN_CYCLES) begin : g_latch_check
    $error("spi_cmd_master: LATCH_CYCLES must be at least %0d", LATCH_MIN_CYCLES);
  end
  // The latch strobe reuses the bit counter, so it must fit in that range.
  if (LATCH_CYCLES > (2 ** BIT_CNT_W)) begin : g_latch_range_check
    $error("spi_cmd_master: LATCH_CYCLES exceeds bit counter range");
  end

  spi_state_e state_r;
  spi_state_e state_nxt_s;

  logic                  tick_s;
  logic                  div_clear_s;
  logic                  last_bit_s;
  logic                  latch_done_s;

  logic [DATA_WIDTH-1:0] tx_r, tx_nxt_s;
  logic [DATA_WIDTH-1:0] rx_r, rx_nxt_s;
  logic [DATA_WIDTH-1:0] rsp_data_r, rsp_data_nxt_s;
  logic [BIT_CNT_W-1:0]  bit_cnt_r, bit_cnt_nxt_s;
  logic                  latch_flag_r, latch_flag_nxt_s;
  logic                  sclk_r, sclk_nxt_s;
  logic                  mosi_r, mosi_nxt_s;
  logic                  ss_n_r, ss_n_nxt_s;
  logic                  busy_r, busy_nxt_s;
  logic                  rsp_valid_r, rsp_valid_nxt_s;
  logic                  latch_data_r, latch_data_nxt_s;

  // The timebase is parked while idle and during the strobe so SETUP and GAP start on a fresh window.
  assign div_clear_s  = (state_r == IDLE) || (state_r == LATCH);
  assign last_bit_s   = (bit_cnt_r == BIT_LAST);
  assign latch_done_s = (bit_cnt_r == LATCH_LAST);

  spi_half_period_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (div_clear_s),
    .tick    (tick_s)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (cmd_valid) state_nxt_s = SETUP;
        else           state_nxt_s = IDLE;
      end
      SETUP: begin
        if (tick_s) state_nxt_s = SHIFT;
        else        state_nxt_s = SETUP;
      end
      SHIFT: begin
        if (tick_s && !sclk_r && last_bit_s) state_nxt_s = HOLD;
        else                                 state_nxt_s = SHIFT;
      end
      HOLD: begin
        if (tick_s && latch_flag_r) state_nxt_s = LATCH;
        else if (tick_s)            state_nxt_s = GAP;
        else                        state_nxt_s = HOLD;
      end
      LATCH: begin
        if (latch_done_s) state_nxt_s = GAP;
        else              state_nxt_s = LATCH;
      end
      GAP: begin
        if (tick_s) state_nxt_s = IDLE;
        else        state_nxt_s = GAP;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next values for the shift registers and the registered SPI/handshake outputs.
  always_comb begin
    tx_nxt_s         = tx_r;
    rx_nxt_s         = rx_r;
    rsp_data_nxt_s   = rsp_data_r;
    bit_cnt_nxt_s    = bit_cnt_r;
    latch_flag_nxt_s = latch_flag_r;
    sclk_nxt_s       = sclk_r;
    mosi_nxt_s       = mosi_r;
    ss_n_nxt_s       = ss_n_r;
    busy_nxt_s       = busy_r;
    rsp_valid_nxt_s  = 1'b0;
    latch_data_nxt_s = latch_data_r;
    case (state_r)
      IDLE: begin
        if (cmd_valid) begin
          tx_nxt_s         = cmd_data;
          rx_nxt_s         = {DATA_WIDTH{1'b0}};
          latch_flag_nxt_s = cmd_latch;
          bit_cnt_nxt_s    = CNT_ZERO;
          ss_n_nxt_s       = 1'b0;
          mosi_nxt_s       = cmd_data[DATA_WIDTH-1];
          busy_nxt_s       = 1'b1;
        end else begin
          ss_n_nxt_s = 1'b1;
          sclk_nxt_s = 1'b0;
          mosi_nxt_s = 1'b0;
        end
      end
      SETUP: begin
        if (tick_s) sclk_nxt_s = 1'b1;
        else        sclk_nxt_s = 1'b0;
      end
      SHIFT: begin
        if (tick_s) begin
          if (sclk_r) begin
            // Falling edge: capture miso late in the bit, then present the next mosi bit.
            sclk_nxt_s = 1'b0;
            rx_nxt_s   = {rx_r[DATA_WIDTH-2:0], miso};
            tx_nxt_s   = {tx_r[DATA_WIDTH-2:0], 1'b0};
            mosi_nxt_s = tx_r[DATA_WIDTH-2];
          end else if (last_bit_s) begin
            sclk_nxt_s = 1'b0;
          end else begin
            sclk_nxt_s    = 1'b1;
            bit_cnt_nxt_s = bit_cnt_r + CNT_ONE;
          end
        end else begin
          sclk_nxt_s = sclk_r;
        end
      end
      HOLD: begin
        if (tick_s) begin
          ss_n_nxt_s      = 1'b1;
          mosi_nxt_s      = 1'b0;
          rsp_data_nxt_s  = rx_r;
          rsp_valid_nxt_s = 1'b1;
          bit_cnt_nxt_s   = CNT_ZERO;
          if (latch_flag_r) latch_data_nxt_s = 1'b1;
          else              latch_data_nxt_s = 1'b0;
        end else begin
          ss_n_nxt_s = 1'b0;
        end
      end
      LATCH: begin
        if (latch_done_s) begin
          latch_data_nxt_s = 1'b0;
        end else begin
          latch_data_nxt_s = 1'b1;
          bit_cnt_nxt_s    = bit_cnt_r + CNT_ONE;
        end
      end
      GAP: begin
        if (tick_s) busy_nxt_s = 1'b0;
        else        busy_nxt_s = 1'b1;
      end
      default: begin
        ss_n_nxt_s       = 1'b1;
        sclk_nxt_s       = 1'b0;
        mosi_nxt_s       = 1'b0;
        busy_nxt_s       = 1'b0;
        latch_data_nxt_s = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      tx_r         <= {DATA_WIDTH{1'b0}};
      rx_r         <= {DATA_WIDTH{1'b0}};
      rsp_data_r   <= {DATA_WIDTH{1'b0}};
      bit_cnt_r    <= CNT_ZERO;
      latch_flag_r <= 1'b0;
      sclk_r       <= 1'b0;
      mosi_r       <= 1'b0;
      ss_n_r       <= 1'b1;
      busy_r       <= 1'b0;
      rsp_valid_r  <= 1'b0;
      latch_data_r <= 1'b0;
    end else begin
      tx_r         <= tx_nxt_s;
      rx_r         <= rx_nxt_s;
      rsp_data_r   <= rsp_data_nxt_s;
      bit_cnt_r    <= bit_cnt_nxt_s;
      latch_flag_r <= latch_flag_nxt_s;
      sclk_r       <= sclk_nxt_s;
      mosi_r       <= mosi_nxt_s;
      ss_n_r       <= ss_n_nxt_s;
      busy_r       <= busy_nxt_s;
      rsp_valid_r  <= rsp_valid_nxt_s;
      latch_data_r <= latch_data_nxt_s;
    end
  end

  assign cmd_ready  = (state_r == IDLE);
  assign rsp_valid  = rsp_valid_r;
  assign rsp_data   = rsp_data_r;
  assign busy       = busy_r;
  assign sclk       = sclk_r;
  assign mosi       = mosi_r;
  assign ss_n       = ss_n_r;
  assign latch_data = latch_data_r;

endmodule
